// File: rtl/pkt_buf_alloc.sv
// Ingress slot allocator and write sequencer for the four-class packet RAM.
// Optional drop counter: define PKT_BUF_ALLOC_DROP_CNT_EN to build it.
module pkt_buf_alloc #(
  parameter int unsigned NSLOT = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         s_axis_rx_valid,
  output logic         s_axis_rx_ready,
  input  logic [511:0] s_axis_rx_data,
  input  logic         s_axis_rx_last,
  input  logic [9:0]   s_axis_rx_len,
  output logic         m_ram_valid,
  input  logic         m_ram_ready,
  output logic [511:0] m_ram_data,
  output logic [15:0]  m_ram_addr,
  output logic         m_ram_wr,
  output logic         m_desc_valid,
  input  logic         m_desc_ready,
  output logic [15:0]  m_desc_addr,
  output logic [9:0]   m_desc_len,
  input  logic         s_free_valid,
  output logic         s_free_ready,
  input  logic [1:0]   s_free_class,
  output logic [31:0]  drop_cnt,
  output logic         free_err
);

  localparam int unsigned HW = (NSLOT > 1) ? $clog2(NSLOT) : 1;
  localparam logic [HW-1:0] HeadOne  = 1;
  localparam logic [HW:0]   UsedOne  = 1;
  localparam logic [HW:0]   UsedFull = (HW+1)'(NSLOT);

  typedef enum logic [2:0] {StIdle, StWrite, StPad, StTrim, StDrop, StDesc} state_e;

  state_e        state_q;
  logic [1:0]    cls_q;
  logic [9:0]    len_q;
  logic [15:0]   addr_q;
  logic [3:0]    bc_q;
  logic [HW-1:0] head_q [4];
  logic [HW:0]   used_q [4];
  logic [HW:0]   used_d [4];
  logic          free_err_q;
  logic          free_rdy_q;

  logic          len_ok;
  logic [1:0]    in_cls;
  logic [13:0]   in_off;
  logic [3:0]    cb;
  logic          bc_last;
  logic          rx_fire;
  logic          ram_fire;
  logic          free_fire;
  logic          alloc_inc;

  assign len_ok = (s_axis_rx_len != 10'd0) && (s_axis_rx_len <= 10'd512);

  always_comb begin
    if (s_axis_rx_len <= 10'd64)       in_cls = 2'd0;
    else if (s_axis_rx_len <= 10'd128) in_cls = 2'd1;
    else if (s_axis_rx_len <= 10'd256) in_cls = 2'd2;
    else                               in_cls = 2'd3;
  end

  // Slot base in beat units: each class slot spans 1<<cls beats.
  assign in_off  = 14'(head_q[in_cls]) << in_cls;
  assign cb      = 4'd1 << cls_q;
  assign bc_last = (bc_q + 4'd1) == cb;

  always_comb begin
    s_axis_rx_ready = 1'b0;
    m_ram_valid     = 1'b0;
    m_ram_data      = '0;
    unique case (state_q)
      StWrite: begin
        m_ram_valid     = s_axis_rx_valid;
        s_axis_rx_ready = m_ram_ready;
        m_ram_data      = s_axis_rx_data;
      end
      StPad:          m_ram_valid     = 1'b1;
      StTrim, StDrop: s_axis_rx_ready = 1'b1;
      default: ;
    endcase
  end

  assign rx_fire      = s_axis_rx_valid & s_axis_rx_ready;
  assign ram_fire     = m_ram_valid & m_ram_ready;
  assign free_fire    = s_free_valid & s_free_ready;
  assign alloc_inc    = (state_q == StWrite) && ram_fire && (bc_q == 4'd0);
  assign m_desc_valid = (state_q == StDesc);
  assign m_ram_addr   = addr_q;
  assign m_desc_addr  = addr_q;
  assign m_desc_len   = len_q;
  assign m_ram_wr     = 1'b1;
  assign s_free_ready = free_rdy_q;
  assign free_err     = free_err_q;

`ifdef PKT_BUF_ALLOC_DROP_CNT_EN
  logic [31:0] drop_q;
  assign drop_cnt = drop_q;
`else
  assign drop_cnt = 32'd0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cls_q   <= '0;
      len_q   <= '0;
      addr_q  <= '0;
      bc_q    <= '0;
      for (int c = 0; c < 4; c++) head_q[c] <= '0;
`ifdef PKT_BUF_ALLOC_DROP_CNT_EN
      drop_q  <= '0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (s_axis_rx_valid) begin
            if (!len_ok || (used_q[in_cls] == UsedFull)) begin
              state_q <= StDrop;
`ifdef PKT_BUF_ALLOC_DROP_CNT_EN
              if (drop_q != 32'hFFFF_FFFF) drop_q <= drop_q + 32'd1;
`endif
            end else begin
              cls_q          <= in_cls;
              len_q          <= s_axis_rx_len;
              addr_q         <= {in_cls, in_off};
              head_q[in_cls] <= head_q[in_cls] + HeadOne;
              bc_q           <= '0;
              state_q        <= StWrite;
            end
          end
        end
        StWrite: begin
          if (ram_fire) begin
            bc_q <= bc_q + 4'd1;
            if (s_axis_rx_last) state_q <= bc_last ? StDesc : StPad;
            else if (bc_last)   state_q <= StTrim;
          end
        end
        StPad: begin
          if (ram_fire) begin
            bc_q <= bc_q + 4'd1;
            if (bc_last) state_q <= StDesc;
          end
        end
        StTrim: if (rx_fire && s_axis_rx_last) state_q <= StDesc;
        StDrop: if (rx_fire && s_axis_rx_last) state_q <= StIdle;
        StDesc: if (m_desc_ready) state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  // Slots return in allocation order, so only the occupancy count is tracked per class.
  always_comb begin
    for (int c = 0; c < 4; c++) begin
      logic inc, dec;
      inc = alloc_inc && (cls_q == 2'(c));
      dec = free_fire && (s_free_class == 2'(c)) && (used_q[c] != '0);
      used_d[c] = used_q[c];
      if (inc && !dec)      used_d[c] = used_q[c] + UsedOne;
      else if (dec && !inc) used_d[c] = used_q[c] - UsedOne;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < 4; c++) used_q[c] <= '0;
      free_err_q <= 1'b0;
      free_rdy_q <= 1'b0;
    end else begin
      for (int c = 0; c < 4; c++) used_q[c] <= used_d[c];
      free_rdy_q <= 1'b1;
      if (free_fire && (used_q[s_free_class] == '0)) free_err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pkt_buf_alloc.sv
// Directed bench for pkt_buf_alloc: class selection, padding, trimming, ring wrap, drops, frees.
module tb_pkt_buf_alloc;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         s_axis_rx_valid;
  logic         s_axis_rx_ready;
  logic [511:0] s_axis_rx_data;
  logic         s_axis_rx_last;
  logic [9:0]   s_axis_rx_len;
  logic         m_ram_valid;
  logic         m_ram_ready;
  logic [511:0] m_ram_data;
  logic [15:0]  m_ram_addr;
  logic         m_ram_wr;
  logic         m_desc_valid;
  logic         m_desc_ready;
  logic [15:0]  m_desc_addr;
  logic [9:0]   m_desc_len;
  logic         s_free_valid;
  logic         s_free_ready;
  logic [1:0]   s_free_class;
  logic [31:0]  drop_cnt;
  logic         free_err;

  int nvec = 0;
  int nmis = 0;
  int pad_cnt = 0;
  logic [15:0]  wa[$];
  logic [511:0] wd[$];
  logic [15:0]  da[$];
  logic [9:0]   dl[$];

  pkt_buf_alloc #(.NSLOT(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axis_rx_valid(s_axis_rx_valid), .s_axis_rx_ready(s_axis_rx_ready),
    .s_axis_rx_data(s_axis_rx_data), .s_axis_rx_last(s_axis_rx_last),
    .s_axis_rx_len(s_axis_rx_len),
    .m_ram_valid(m_ram_valid), .m_ram_ready(m_ram_ready), .m_ram_data(m_ram_data),
    .m_ram_addr(m_ram_addr), .m_ram_wr(m_ram_wr),
    .m_desc_valid(m_desc_valid), .m_desc_ready(m_desc_ready),
    .m_desc_addr(m_desc_addr), .m_desc_len(m_desc_len),
    .s_free_valid(s_free_valid), .s_free_ready(s_free_ready), .s_free_class(s_free_class),
    .drop_cnt(drop_cnt), .free_err(free_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (m_ram_valid && m_ram_ready) begin
      wa.push_back(m_ram_addr);
      wd.push_back(m_ram_data);
      if (!s_axis_rx_ready) pad_cnt++;
    end
    if (m_desc_valid && m_desc_ready) begin
      da.push_back(m_desc_addr);
      dl.push_back(m_desc_len);
    end
  end

  function automatic logic [511:0] mkdata(input logic [7:0] tag, input int i);
    return {{63{tag}}, 8'(i)};
  endfunction

  function automatic logic [31:0] exp_drop(input int n);
`ifdef PKT_BUF_ALLOC_DROP_CNT_EN
    return 32'(n);
`else
    return 32'(n) & 32'd0;
`endif
  endfunction

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nmis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    wa.delete(); wd.delete(); da.delete(); dl.delete();
    pad_cnt = 0;
  endtask

  task automatic send_pkt(input string nm, input logic [7:0] tag, input int len, input int nb);
    int i = 0;
    int guard = 0;
    logic fire;
    s_axis_rx_valid = 1'b1;
    s_axis_rx_len   = 10'(len);
    while (i < nb && guard < 200) begin
      s_axis_rx_data = mkdata(tag, i);
      s_axis_rx_last = (i == nb - 1);
      @(negedge clk);
      fire = s_axis_rx_valid && s_axis_rx_ready;
      tick();
      if (fire) i++;
      guard++;
    end
    s_axis_rx_valid = 1'b0;
    s_axis_rx_last  = 1'b0;
    chk({nm, " beats consumed"}, 512'(i), 512'(nb));
  endtask

  task automatic run_pkt(input string nm, input logic [7:0] tag, input int len, input int nb,
                         input logic [15:0] ea, input int enw, input int endesc);
    clear_mon();
    send_pkt(nm, tag, len, nb);
    repeat (12) tick();
    chk({nm, " ram writes"}, 512'(wa.size()), 512'(enw));
    if (enw > 0) begin
      chk({nm, " first addr"}, (wa.size() > 0) ? 512'(wa[0]) : 'x, 512'(ea));
      chk({nm, " last addr"}, (wa.size() > 0) ? 512'(wa[wa.size()-1]) : 'x, 512'(ea));
      chk({nm, " beat0 data"}, (wd.size() > 0) ? wd[0] : 'x, mkdata(tag, 0));
    end
    chk({nm, " desc count"}, 512'(da.size()), 512'(endesc));
    if (endesc > 0) begin
      chk({nm, " desc addr"}, (da.size() > 0) ? 512'(da[0]) : 'x, 512'(ea));
      chk({nm, " desc len"}, (dl.size() > 0) ? 512'(dl[0]) : 'x, 512'(len));
    end
  endtask

  task automatic do_free(input logic [1:0] cls);
    s_free_valid = 1'b1;
    s_free_class = cls;
    tick();
    s_free_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    s_axis_rx_valid = 1'b0; s_axis_rx_data = '0; s_axis_rx_last = 1'b0; s_axis_rx_len = '0;
    m_ram_ready = 1'b1; m_desc_ready = 1'b1;
    s_free_valid = 1'b0; s_free_class = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst m_ram_valid", 512'(m_ram_valid), 512'(0));
    chk("rst rx_ready", 512'(s_axis_rx_ready), 512'(0));
    chk("rst desc_valid", 512'(m_desc_valid), 512'(0));
    chk("rst free_ready", 512'(s_free_ready), 512'(0));
    chk("rst ram_wr", 512'(m_ram_wr), 512'(1));
    chk("rst ram_addr", 512'(m_ram_addr), 512'(0));
    chk("rst ram_data", m_ram_data, 512'(0));
    chk("rst desc_addr_len", 512'({m_desc_addr, m_desc_len}), 512'(0));
    chk("rst drop_cnt", 512'(drop_cnt), 512'(0));
    chk("rst free_err", 512'(free_err), 512'(0));
    rst_n = 1'b1;
    repeat (2) tick();
    chk("free_ready after rst", 512'(s_free_ready), 512'(1));

    run_pkt("c0 first", 8'h11, 64, 1, 16'h0000, 1, 1);
    run_pkt("c0 second", 8'h12, 64, 1, 16'h0001, 1, 1);
    run_pkt("c2 first", 8'h21, 200, 4, 16'h8000, 4, 1);
    run_pkt("c2 second", 8'h22, 200, 4, 16'h8004, 4, 1);

    run_pkt("c3 pad", 8'h31, 300, 5, 16'hC000, 8, 1);
    chk("c3 pad cycles rx_ready low", 512'(pad_cnt), 512'(3));
    chk("c3 last data beat", (wd.size() > 4) ? wd[4] : 'x, mkdata(8'h31, 4));
    chk("c3 pad beat zero", (wd.size() > 7) ? wd[7] : 'x, 512'(0));

    run_pkt("c1 trim", 8'h41, 65, 4, 16'h4000, 2, 1);
    chk("c1 beat1 data", (wd.size() > 1) ? wd[1] : 'x, mkdata(8'h41, 1));

    for (int k = 2; k < 16; k++) run_pkt("c0 fill", 8'(k), 10, 1, 16'(k), 1, 1);
    run_pkt("c0 full drop", 8'h50, 64, 1, 16'h0000, 0, 0);
    chk("drop_cnt full", 512'(drop_cnt), 512'(exp_drop(1)));
    do_free(2'd0);
    run_pkt("c0 wrap", 8'h51, 64, 1, 16'h0000, 1, 1);

    run_pkt("len0 drop", 8'h60, 0, 2, 16'h0000, 0, 0);
    chk("drop_cnt len0", 512'(drop_cnt), 512'(exp_drop(2)));
    run_pkt("len600 drop", 8'h61, 600, 1, 16'h0000, 0, 0);
    chk("drop_cnt len600", 512'(drop_cnt), 512'(exp_drop(3)));

    do_free(2'd1);
    tick();
    chk("free_err after valid free", 512'(free_err), 512'(0));
    do_free(2'd1);
    tick();
    chk("free_err empty class", 512'(free_err), 512'(1));

    // Class 3 holds one slot; free it in the same cycle a new class-3 first beat lands.
    clear_mon();
    s_axis_rx_len = 10'd257; s_axis_rx_data = mkdata(8'h70, 0);
    s_axis_rx_last = 1'b1; s_axis_rx_valid = 1'b1;
    tick();
    chk("c3 write state rx_ready", 512'(s_axis_rx_ready), 512'(1));
    s_free_valid = 1'b1; s_free_class = 2'd3;
    tick();
    s_free_valid = 1'b0; s_axis_rx_valid = 1'b0; s_axis_rx_last = 1'b0;
    chk("c3 used after alloc+free", 512'(dut.used_q[3]), 512'(1));
    repeat (12) tick();
    chk("c3 same-cycle writes", 512'(wa.size()), 512'(8));
    chk("c3 same-cycle addr", (wa.size() > 0) ? 512'(wa[0]) : 'x, 512'(16'hC008));
    chk("c3 same-cycle desc", (da.size() > 0) ? 512'({da[0], dl[0]}) : 'x,
        512'({16'hC008, 10'd257}));
    chk("free_err sticky", 512'(free_err), 512'(1));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

// File: doc/pkt_buf_alloc.md
# pkt_buf_alloc

Ingress slot allocator and write sequencer that sits directly upstream of the four-class packet RAM (`ram`), driving its write port.
- Accepts 512-bit packet streams with a byte length on the first beat.
- Picks the smallest size class that fits, allocates a slot from a per-class ring, and writes the packet into the RAM, zero-padding to the full class beat count.
- Emits a descriptor (RAM address, length) downstream.
- Slots are returned through a free port.

## Interface
Parameters:
- `NSLOT`, 16: slots per class; power of two, 2..2048.

Ports:
- `clk` in 1: single clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `s_axis_rx_valid` in 1, `s_axis_rx_ready` out 1: ingress handshake.
- `s_axis_rx_data` in 512: beat data.
- `s_axis_rx_last` in 1: final beat.
- `s_axis_rx_len` in 10: packet bytes; sampled on first beat only.
- `m_ram_valid` out 1, `m_ram_ready` in 1: write handshake to RAM port.
- `m_ram_data` out 512: write data.
- `m_ram_addr` out 16: slot base address; held for the whole packet.
- `m_ram_wr` out 1: read_or_write; constant 1 after reset.
- `m_desc_valid` out 1, `m_desc_ready` in 1: descriptor handshake.
- `m_desc_addr` out 16: slot base address.
- `m_desc_len` out 10: packet bytes.
- `s_free_valid` in 1, `s_free_ready` out 1: slot return handshake.
- `s_free_class` in 2: class of the returned slot.
- `drop_cnt` out 32: dropped packets, saturating.
- `free_err` out 1: sticky; set on a free to an empty-allocated class.

## Operation
- Class from len:
  - 1..64 → 0
  - 65..128 → 1
  - 129..256 → 2
  - 257..512 → 3
  - len 0 or >512 → drop.
- Class beats `CB = 1<<cls`. Data beats `DB = ceil(len/64)`.
- Per class: `head` (log2 NSLOT bits, wraps), `used` (0..NSLOT). The ring is full when `used == NSLOT`.
- Slot address: `m_ram_addr = {cls, 14'(head << cls)}`, in beat units.
- Slots are freed in allocation order per class. Each free increments that class's tail implicitly, so `used` decrements.
- States:
  - IDLE:
    - Wait for a first beat.
    - If len is invalid or the ring is full: go to DROP, increment `drop_cnt`, and consume the beat (ready=1).
    - Otherwise: latch cls/len/addr and advance `head`. Increment `used` at the first beat's acceptance by RAM. Go to WRITE.
    - The first beat is passed in WRITE, not consumed in IDLE.
  - WRITE:
    - Combinational pass-through: `m_ram_valid = s_axis_rx_valid`, `s_axis_rx_ready = m_ram_ready`, and `m_ram_data` is the input data.
    - Count accepted beats `bc`.
    - On a last beat accepted with `bc+1 < CB`: go to PAD.
    - On a last beat accepted with `bc+1 == CB`: go to DESC.
    - On a non-last beat accepted with `bc+1 == CB`: go to TRIM.
  - PAD:
    - `s_axis_rx_ready = 0`, `m_ram_valid = 1`, data all zero.
    - Stay until `CB` total beats are accepted, then go to DESC.
  - TRIM:
    - `s_axis_rx_ready = 1` and `m_ram_valid = 0`.
    - Discard beats until last is accepted, then go to DESC.
  - DROP: consume beats until last is accepted, then go to IDLE. No RAM or descriptor traffic.
  - DESC:
    - `m_desc_valid = 1` with the latched addr/len.
    - On `m_desc_ready`, go to IDLE.
- A packet whose `s_axis_rx_last` arrives on its first beat behaves the same as above.
- `len` is authoritative for the class. DB vs actual beat count mismatch is handled only by PAD/TRIM.
- Free port:
  - `s_free_ready = 1` always.
  - On a free to a class with `used == 0`: set `free_err` and leave counters unchanged.
  - Allocation and free to the same class in one cycle leave `used` unchanged.

## Timing
- Reset values:
  - All valid/ready outputs 0.
  - `m_ram_data`, `m_ram_addr`, `m_desc_addr`, `m_desc_len`, `drop_cnt` 0.
  - `m_ram_wr` 1, `free_err` 0.
  - All heads and used counts 0; state IDLE.
- Reset mid-packet returns to IDLE immediately. Downstream RAM is reset in the same domain.
- Ingress-to-RAM latency is 0 cycles in WRITE, since the path is combinational.
- `m_desc_valid` rises the cycle after the final RAM beat or final TRIM beat is accepted.
- Throughput: one beat per cycle when `m_ram_ready=1`. There is a 1-cycle IDLE decision bubble per packet plus the DESC cycle(s).
- `s_axis_rx_ready` is 0 in IDLE until the decision cycle completes. The first beat is then accepted in WRITE or DROP.

## Configuration
- `PKT_BUF_ALLOC_DROP_CNT_EN`
  - Defined: `drop_cnt` counts dropped packets (invalid len or full ring), saturating at 0xFFFFFFFF.
  - Undefined: the counter is not built; `drop_cnt` is tied to 0. Drop behaviour is otherwise identical.

## Test plan
- len=64, 1 beat, ready=1 → one RAM write at addr 0x0000, then desc (0x0000, 64). Second such packet → addr 0x0001.
- len=200, 4 beats → class 2, RAM writes at 0x8000, desc (0x8000, 200). Next class-2 packet → 0x8004.
- len=300 with last on beat 5 → 5 data beats plus 3 zero beats to 0xC000; desc len 300, ingress ready low during PAD.
- len=65 with last on beat 4 → 2 RAM beats, 2 beats trimmed, desc (0x4000, 65).
- NSLOT=16: 17 class-0 packets without frees → 17th dropped with `drop_cnt`=1 (macro defined) and no RAM traffic. One free of class 0 → next packet accepted at 0x0000 (head wrapped).
- `len=0` packet → dropped. A class-1 free with `used=0` → `free_err`=1. Same-cycle alloc and free on class 3 → `used` unchanged.
